// File: rtl/sf500_pkg.sv
// Shared types and constants for the SF500 Zorro II AutoConfig responder.
package sf500_pkg;

  typedef enum logic [1:0] {
    UNCONF     = 2'd0,
    CONFIGURED = 2'd1,
    SHUTUP     = 2'd2
  } ac_state_t;

  // Register offsets are byte offsets inside the $E8xxxx window.
  localparam logic [6:0] OFS_TYPE    = 7'h00;
  localparam logic [6:0] OFS_SIZE    = 7'h02;
  localparam logic [6:0] OFS_BASE    = 7'h48;
  localparam logic [6:0] OFS_SHUTUP  = 7'h4C;
  localparam logic [6:0] OFS_ROM_END = 7'h40;

  localparam logic [3:0] TYPE_Z2_MEM = 4'b1110;
  localparam logic [3:0] SIZE_4MB    = 4'b0111;
  localparam logic [3:0] SIZE_8MB    = 4'b0000;

  localparam logic [7:0] AUTOCONFIG_BASE = 8'hE8;

endpackage

// File: rtl/autoconfig_rom.sv
// Combinational AutoConfig nibble ROM; inversion of the inverted registers is applied here.
// Serial number nibbles are only presented when AUTOCONFIG_SERIAL_EN is defined.
module autoconfig_rom
  import sf500_pkg::*;
#(
  parameter logic [15:0] MANUFACTURER = 16'h0000,
  parameter logic [7:0]  PRODUCT      = 8'h00,
  parameter logic [31:0] SERIAL       = 32'h0000_0000
) (
  input  logic [5:0] index,
  input  logic       JP2,
  output logic [3:0] nibble
);

  logic [6:0] ofs;
  logic [3:0] raw;
  logic       invert;

  assign ofs = {index, 1'b0};

  always_comb begin
    raw    = 4'h0;
    invert = 1'b0;
    if (ofs == OFS_TYPE) begin
      raw = TYPE_Z2_MEM;
    end else if (ofs == OFS_SIZE) begin
      raw = JP2 ? SIZE_8MB : SIZE_4MB;
    end else if (ofs < OFS_ROM_END) begin
      // Everything from $04 to $3E is stored inverted; unused slots read as ~0.
      invert = 1'b1;
      case (ofs)
        7'h04:   raw = PRODUCT[7:4];
        7'h06:   raw = PRODUCT[3:0];
        7'h10:   raw = MANUFACTURER[15:12];
        7'h12:   raw = MANUFACTURER[11:8];
        7'h14:   raw = MANUFACTURER[7:4];
        7'h16:   raw = MANUFACTURER[3:0];
`ifdef AUTOCONFIG_SERIAL_EN
        7'h18:   raw = SERIAL[31:28];
        7'h1A:   raw = SERIAL[27:24];
        7'h1C:   raw = SERIAL[23:20];
        7'h1E:   raw = SERIAL[19:16];
        7'h20:   raw = SERIAL[15:12];
        7'h22:   raw = SERIAL[11:8];
        7'h24:   raw = SERIAL[7:4];
        7'h26:   raw = SERIAL[3:0];
`endif
        default: raw = 4'h0;
      endcase
    end
  end

`ifndef AUTOCONFIG_SERIAL_EN
  logic unused_serial;
  assign unused_serial = ^SERIAL;
`endif

  assign nibble = invert ? ~raw : raw;

endmodule

// File: rtl/autoconfig_z2.sv
// Zorro II AutoConfig responder for the SF500 fast RAM: ROM readout, base latch, config chain.
// Optional serial-number readout is enabled with AUTOCONFIG_SERIAL_EN.
module autoconfig_z2
  import sf500_pkg::*;
#(
  parameter logic [15:0] MANUFACTURER = 16'h0000,
  parameter logic [7:0]  PRODUCT      = 8'h00,
  parameter logic [31:0] SERIAL       = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [23:1] A,
  input  logic        RW_n,
  input  logic        AS_CPU_n,
  input  logic        UDS_n,
  input  logic [3:0]  D_IN,
  input  logic        JP2,
  input  logic        CONFIG_IN_n,
  output logic [3:0]  D_OUT,
  output logic        D_OE,
  output logic [2:0]  BASE_RAM,
  output logic        RAM_CONFIGURED_n,
  output logic        CONFIG_OUT_n,
  output logic [1:0]  dbg_state
);

  ac_state_t  state, state_next;
  logic       window, bus_active, read_hit, wr_strobe;
  logic       wr_q, wr_qq, wr_act;
  logic [6:0] wr_ofs;
  logic [2:0] wr_data;
  logic [3:0] rom_nibble;

  assign window     = (A[23:16] == AUTOCONFIG_BASE) && !CONFIG_IN_n && (state == UNCONF);
  assign bus_active = !AS_CPU_n && !UDS_n;
  assign read_hit   = window && RW_n && bus_active;
  assign wr_strobe  = window && !RW_n && bus_active;
  // One action per bus cycle: act only on the first cycle the registered strobe is high.
  assign wr_act     = wr_q && !wr_qq;

  autoconfig_rom #(
    .MANUFACTURER(MANUFACTURER),
    .PRODUCT     (PRODUCT),
    .SERIAL      (SERIAL)
  ) u_rom (
    .index (A[6:1]),
    .JP2   (JP2),
    .nibble(rom_nibble)
  );

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state <= UNCONF;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == UNCONF && wr_act) begin
      if (wr_ofs == OFS_BASE)        state_next = CONFIGURED;
      else if (wr_ofs == OFS_SHUTUP) state_next = SHUTUP;
    end
  end

  always_comb begin
    RAM_CONFIGURED_n = (state != CONFIGURED);
    CONFIG_OUT_n     = (state == UNCONF);
    dbg_state        = state;
  end

  // Offset and data are captured with the strobe so the action does not depend on the bus still holding them.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_q    <= 1'b0;
      wr_qq   <= 1'b0;
      wr_ofs  <= 7'h00;
      wr_data <= 3'b000;
    end else begin
      wr_q  <= wr_strobe;
      wr_qq <= wr_q;
      if (wr_strobe && !wr_q) begin
        wr_ofs  <= {A[6:1], 1'b0};
        wr_data <= D_IN[3:1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      BASE_RAM <= 3'b000;
    end else if (state == UNCONF && wr_act && wr_ofs == OFS_BASE) begin
      BASE_RAM <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      D_OE  <= 1'b0;
      D_OUT <= 4'hF;
    end else begin
      D_OE  <= read_hit;
      D_OUT <= read_hit ? rom_nibble : 4'hF;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{A[15:7], D_IN[0]};

endmodule

// File: tb/tb_autoconfig_z2.sv
// Scoreboard bench for autoconfig_z2: randomized ROM reads and config writes against a behavioural model.
module tb_autoconfig_z2;

  localparam logic [15:0] MANUF = 16'h1234;
  localparam logic [7:0]  PROD  = 8'h5A;
  localparam logic [31:0] SER   = 32'hDEAD_BEEF;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic [23:1] A = '0;
  logic        RW_n = 1'b1, AS_CPU_n = 1'b1, UDS_n = 1'b1;
  logic [3:0]  D_IN = '0;
  logic        JP2 = 1'b0;
  logic        CONFIG_IN_n = 1'b0;
  logic [3:0]  D_OUT;
  logic        D_OE;
  logic [2:0]  BASE_RAM;
  logic        RAM_CONFIGURED_n, CONFIG_OUT_n;
  logic [1:0]  dbg_state;

  autoconfig_z2 #(.MANUFACTURER(MANUF), .PRODUCT(PROD), .SERIAL(SER)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .A(A), .RW_n(RW_n), .AS_CPU_n(AS_CPU_n), .UDS_n(UDS_n),
    .D_IN(D_IN), .JP2(JP2), .CONFIG_IN_n(CONFIG_IN_n), .D_OUT(D_OUT), .D_OE(D_OE),
    .BASE_RAM(BASE_RAM), .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .CONFIG_OUT_n(CONFIG_OUT_n),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  // Behavioural model of the board's configuration state.
  bit       m_configured = 0;
  bit       m_shutup = 0;
  bit [2:0] m_base = 0;

  function automatic logic [3:0] model_nib(input int ofs, input bit jp2);
    logic [31:0] v;
    if (ofs == 0) return 4'hE;
    if (ofs == 2) return jp2 ? 4'h0 : 4'h7;
    if (ofs >= 4 && ofs <= 6) begin
      v = {24'h0, ~PROD};
      return v[4*(1-(ofs-4)/2) +: 4];
    end
    if (ofs >= 16 && ofs <= 22) begin
      v = {16'h0, ~MANUF};
      return v[4*(3-(ofs-16)/2) +: 4];
    end
`ifdef AUTOCONFIG_SERIAL_EN
    if (ofs >= 24 && ofs <= 38) begin
      v = ~SER;
      return v[4*(7-(ofs-24)/2) +: 4];
    end
`endif
    if (ofs < 64) return 4'hF;
    return 4'h0;
  endfunction

  function automatic bit model_open();
    return !m_configured && !m_shutup && !CONFIG_IN_n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cfg(input string name);
    check({name, "_base"}, 32'(BASE_RAM), 32'(m_base));
    check({name, "_ramcfg_n"}, 32'(RAM_CONFIGURED_n), 32'(!m_configured));
    check({name, "_cfgout_n"}, 32'(CONFIG_OUT_n), 32'(!(m_configured || m_shutup)));
  endtask

  // Monitor: every rising D_OE presents one nibble, matched against the expected queue.
  logic oe_prev = 1'b0;
  always @(negedge CLK) begin
    if (D_OE && !oe_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_doe", 32'(D_OE), 32'h0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("read_nibble", 32'(D_OUT), 32'(e));
      end
    end
    oe_prev <= D_OE;
  end

  // Driver tasks
  task automatic bus_idle();
    AS_CPU_n = 1'b1;
    UDS_n    = 1'b1;
    RW_n     = 1'b1;
  endtask

  task automatic bus_read(input int ofs, input int hold, input string tag);
    bit open;
    @(negedge CLK);
    A = {8'hE8, 9'h000, 6'(ofs / 2)};
    RW_n = 1'b1; AS_CPU_n = 1'b0; UDS_n = 1'b0;
    open = model_open();
    if (open) exp_q.push_back(model_nib(ofs, JP2));
    @(negedge CLK);
    check({tag, "_doe"}, 32'(D_OE), 32'(open));
    repeat (hold - 1) @(negedge CLK);
    bus_idle();
    @(negedge CLK);
    check({tag, "_doe_drop"}, 32'(D_OE), 32'h0);
  endtask

  task automatic bus_write(input int ofs, input logic [3:0] d, input int hold, input string tag);
    bit acts;
    @(negedge CLK);
    A = {8'hE8, 9'h000, 6'(ofs / 2)};
    D_IN = d;
    RW_n = 1'b0; AS_CPU_n = 1'b0; UDS_n = 1'b0;
    acts = model_open();
    @(negedge CLK);
    check_cfg({tag, "_pre"});
    if (acts) begin
      if (ofs == 'h48) begin
        m_base = d[3:1];
        m_configured = 1;
      end else if (ofs == 'h4C) begin
        m_shutup = 1;
      end
    end
    @(negedge CLK);
    check_cfg(tag);
    repeat (hold - 2) @(negedge CLK);
    check_cfg({tag, "_held"});
    check({tag, "_doe"}, 32'(D_OE), 32'h0);
    bus_idle();
    @(negedge CLK);
    check({tag, "_doe_after"}, 32'(D_OE), 32'h0);
  endtask

  task automatic reset_pulse(input string tag);
    @(posedge CLK);
    #3 RESET_n = 1'b0;
    #1;
    m_configured = 0; m_shutup = 0; m_base = 0;
    check_cfg(tag);
    check({tag, "_doe"}, 32'(D_OE), 32'h0);
    check({tag, "_dout"}, 32'(D_OUT), 32'hF);
    bus_idle();
    @(negedge CLK);
    RESET_n = 1'b1;
  endtask

  initial begin
    int ofs;
    bus_idle();
    repeat (3) @(negedge CLK);
    check_cfg("reset");
    check("reset_doe", 32'(D_OE), 32'h0);
    check("reset_dout", 32'(D_OUT), 32'hF);
    RESET_n = 1'b1;

    // Directed ROM reads
    JP2 = 1'b0;
    bus_read('h00, 2, "rd_type");
    bus_read('h02, 2, "rd_size4");
    bus_read('h10, 3, "rd_manuf_hi");
    JP2 = 1'b1;
    bus_read('h02, 2, "rd_size8");
    bus_read('h08, 2, "rd_reserved");
    bus_read('h18, 2, "rd_serial0");
    bus_read('h42, 2, "rd_ofs42");
    bus_read('h7E, 2, "rd_ofs7e");

    // Randomized reads, including with the chain closed
    for (int i = 0; i < 40; i++) begin
      JP2 = 1'($urandom_range(0, 1));
      CONFIG_IN_n = ($urandom_range(0, 3) == 0);
      ofs = 2 * $urandom_range(0, 63);
      bus_read(ofs, $urandom_range(1, 4), "rd_rand");
    end
    CONFIG_IN_n = 1'b0;

    // Writes that must be ignored
    CONFIG_IN_n = 1'b1;
    bus_write('h48, 4'b1010, 3, "wr_chain_closed");
    CONFIG_IN_n = 1'b0;
    bus_write('h4A, 4'b1110, 3, "wr_4a");
    for (int i = 0; i < 8; i++) begin
      do ofs = 2 * $urandom_range(0, 63); while (ofs == 'h48 || ofs == 'h4C);
      bus_write(ofs, 4'($urandom_range(0, 15)), $urandom_range(2, 4), "wr_ignored");
    end
    bus_read('h00, 2, "rd_still_open");

    // Configure, then confirm the window is closed and terminal
    bus_write('h48, 4'b0010, 4, "wr_base");
    bus_read('h00, 2, "rd_after_cfg");
    bus_write('h4C, 4'b0000, 3, "wr_shut_after_cfg");
    reset_pulse("rst_cfg");

    // Shut-up path
    bus_read('h02, 2, "rd_after_rst");
    bus_write('h4C, 4'b1111, 3, "wr_shutup");
    bus_write('h48, 4'b1110, 3, "wr_base_after_shut");
    bus_read('h00, 2, "rd_after_shut");
    reset_pulse("rst_shut");

    // Chain closed, then opened
    CONFIG_IN_n = 1'b1;
    bus_write('h48, 4'b1100, 3, "wr_closed2");
    CONFIG_IN_n = 1'b0;
    bus_write('h48, 4'($urandom_range(0, 15)), 2, "wr_open2");
    bus_read('h00, 2, "rd_after_cfg2");

    repeat (3) @(negedge CLK);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/autoconfig_z2.md
# autoconfig_z2

Zorro II AutoConfig responder for the SF500 fast RAM. Presents the board's configuration nibbles in the $E80000–$E8FFFF window while unconfigured and latches the base address the OS writes. Drives BASE_RAM and RAM_CONFIGURED_n into the fast-RAM decoder, and passes the configuration chain on via CONFIG_OUT_n.

## Interface
- MANUFACTURER, 16'h0000, Zorro manufacturer ID.
- PRODUCT, 8'h00, product number.
- SERIAL, 32'h0000_0000, serial number (used only with AUTOCONFIG_SERIAL_EN).
- CLK  in  1  CPU clock (7.09 MHz); all state updates on the rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- A  in  23 (A[23:1])  CPU address.
- RW_n, AS_CPU_n, UDS_n  in  1 each  68000 bus strobes, synchronous to CLK.
- D_IN  in  4  CPU data D[15:12].
- JP2  in  1  high = 8 MB board, low = 4 MB board.
- CONFIG_IN_n  in  1  chain enable; low = this board may configure.
- D_OUT  out  4  nibble for D[15:12].
- D_OE  out  1  drive D[15:12].
- BASE_RAM  out  3  latched A[23:21] of the assigned base.
- RAM_CONFIGURED_n  out  1  low once a base is assigned.
- CONFIG_OUT_n  out  1  low once configured or shut up.

## Operation
- States: UNCONF, CONFIGURED, SHUTUP.
- window = A[23:16]==8'hE8 && !CONFIG_IN_n && state==UNCONF.
- Read hit = window && RW_n && !AS_CPU_n && !UDS_n.
- Nibble index is A[6:1]. Register offsets are byte offsets.
- ROM contents, returned as stored (not inverted):
  - $00 = 4'b1110 (Zorro II, link into the memory list).
  - $02 = size code: 4'b0000 (8 MB) when JP2, else 4'b0111 (4 MB).
  - $40/$42 = 4'h0.
- ROM contents, returned inverted:
  - $04/$06 = PRODUCT[7:4]/[3:0].
  - $10–$16 = MANUFACTURER, high nibble first.
  - $18–$26 = SERIAL, high nibble first.
  - All other offsets $08–$3E read inverted zero = 4'hF.
- Offsets $44–$7E read 4'h0.
- Write strobe = window && !RW_n && !AS_CPU_n && !UDS_n. It is registered, and only its rising edge acts, so each bus cycle acts exactly once.
- Write edge at $48: BASE_RAM <= D_IN[3:1]. The state then becomes CONFIGURED and RAM_CONFIGURED_n goes low.
- Write edge at $4C: state becomes SHUTUP. BASE_RAM stays unchanged and RAM_CONFIGURED_n stays high.
- Writes at $4A and all other offsets are ignored.
- CONFIG_OUT_n is low in CONFIGURED and SHUTUP.
- CONFIGURED and SHUTUP are terminal until reset. The window closes in both, so further $E8xxxx accesses are ignored and D_OE stays 0.
- CONFIG_IN_n high: the window is closed and state holds. A write presented while CONFIG_IN_n is high has no effect.

## Timing
- Reset values:
  - state UNCONF, BASE_RAM 3'b000, RAM_CONFIGURED_n 1, CONFIG_OUT_n 1.
  - D_OE 0, D_OUT 4'hF, write-strobe register 0.
- D_OUT and D_OE are registered:
  - Valid on the first CLK edge after the read hit is sampled.
  - D_OE drops on the first edge after AS_CPU_n is sampled high.
- Config write: BASE_RAM, RAM_CONFIGURED_n and CONFIG_OUT_n update on the second rising edge after the strobe is first sampled (edge register, then action).
- A strobe held for many cycles causes one action only. A new action requires AS_CPU_n to deassert for at least one sampled cycle.
- A write and a read cannot overlap (same strobes). When a write completes, D_OE is 0 on the following edge.
- RESET_n asserted mid-cycle clears everything immediately. No partial latch survives.

## Configuration
- AUTOCONFIG_SERIAL_EN defined: $18–$26 return inverted SERIAL.
- Undefined: the SERIAL parameter is unused and $18–$26 read 4'hF, like the other reserved offsets.

## Structure
- Package sf500_pkg holds:
  - State enum (UNCONF, CONFIGURED, SHUTUP).
  - Offset constants (OFS_TYPE, OFS_SIZE, OFS_BASE = 7'h48, OFS_SHUTUP = 7'h4C).
  - Size codes SIZE_4MB = 4'b0111 and SIZE_8MB = 4'b0000.
  - AUTOCONFIG_BASE = 8'hE8.
- One sub-module, autoconfig_rom: combinational; index + JP2 + parameters -> nibble, with inversion applied inside. The top level holds the state machine, strobe edge register and output registers.

## Test plan
- Reset, JP2=0, read $E80000 and $E80002: D_OUT = 4'hE, then 4'h7. Read $E80010 with MANUFACTURER=16'h1234: D_OUT = 4'hE.
- JP2=1, read $E80002: D_OUT = 4'h0. Read $E80008: D_OUT = 4'hF.
- Write D_IN=4'b0010 at $E80048, strobe held 4 cycles: BASE_RAM = 3'b001 and RAM_CONFIGURED_n = 0 two edges after first sample; CONFIG_OUT_n = 0; later read $E80000 gives D_OE = 0.
- Write $E8004C: CONFIG_OUT_n = 0, RAM_CONFIGURED_n = 1, BASE_RAM = 000. A subsequent $E80048 write is ignored.
- CONFIG_IN_n = 1, write $E80048: no change. Then CONFIG_IN_n = 0, repeat the write: configures.
- RESET_n pulsed while configured: all outputs return to reset values asynchronously. Build without AUTOCONFIG_SERIAL_EN: $E80018 reads 4'hF.
